// File: rtl/ml_dma_requester.sv
// rtl/ml_dma_requester.sv - word-by-word copy engine driving the ML port of the UltraRAM controller
module ml_dma_requester #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int LEN_W     = 16,
    parameter int ADDR_STEP = 32,
    parameter int TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  length,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [LEN_W-1:0]  words_done,
    output logic [ADDR_W-1:0] ml_addr,
    output logic [DATA_W-1:0] ml_data_in,
    output logic              ml_we,
    output logic              ml_re,
    input  logic [DATA_W-1:0] ml_data_out,
    input  logic              ml_ready
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RD    = 3'd1;
    localparam logic [2:0] S_GAP_R = 3'd2;
    localparam logic [2:0] S_WR    = 3'd3;
    localparam logic [2:0] S_GAP_W = 3'd4;
    localparam logic [2:0] S_FIN   = 3'd5;

    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(ADDR_STEP);
    localparam logic [WD_W-1:0]   WD_LAST = WD_W'(TIMEOUT - 1);

    logic [2:0]        r_state;
    logic [ADDR_W-1:0] r_src;
    logic [ADDR_W-1:0] r_dst;
    logic [LEN_W-1:0]  r_len;
    logic [DATA_W-1:0] r_hold;
    logic [WD_W-1:0]   r_wd;
    logic              r_busy;
    logic              r_done;
    logic              r_error;
    logic [LEN_W-1:0]  r_words;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data_in;
    logic              r_we;
    logic              r_re;

    logic w_last;
    logic w_wd_expired;

    assign w_last       = (r_words + LEN_W'(1)) == r_len;
    assign w_wd_expired = (r_wd == WD_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_src     <= '0;
            r_dst     <= '0;
            r_len     <= '0;
            r_hold    <= '0;
            r_wd      <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
            r_words   <= '0;
            r_addr    <= '0;
            r_data_in <= '0;
            r_we      <= 1'b0;
            r_re      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_src   <= src_addr;
                        r_dst   <= dst_addr;
                        r_len   <= length;
                        r_words <= '0;
                        r_error <= 1'b0;
                        r_busy  <= 1'b1;
                        r_wd    <= '0;
                        if (length == '0) begin
                            r_state <= S_FIN;
                        end else begin
                            r_state <= S_RD;
                            r_re    <= 1'b1;
                            r_addr  <= src_addr;
                        end
                    end
                end
                // A completing beat always wins over abort and the watchdog.
                S_RD: begin
                    if (ml_ready) begin
                        r_hold  <= ml_data_out;
                        r_src   <= r_src + STEP;
                        r_re    <= 1'b0;
                        r_state <= abort ? S_FIN : S_GAP_R;
                    end else if (abort) begin
                        r_re    <= 1'b0;
                        r_state <= S_FIN;
                    end else if (w_wd_expired) begin
                        r_re    <= 1'b0;
                        r_error <= 1'b1;
                        r_state <= S_FIN;
                    end else begin
                        r_wd <= r_wd + 1'b1;
                    end
                end
                S_GAP_R: begin
                    if (abort) begin
                        r_state <= S_FIN;
                    end else begin
                        r_state   <= S_WR;
                        r_we      <= 1'b1;
                        r_addr    <= r_dst;
                        r_data_in <= r_hold;
                        r_wd      <= '0;
                    end
                end
                S_WR: begin
                    if (ml_ready) begin
                        r_dst   <= r_dst + STEP;
                        r_words <= r_words + 1'b1;
                        r_we    <= 1'b0;
                        r_state <= (abort || w_last) ? S_FIN : S_GAP_W;
                    end else if (abort) begin
                        r_we    <= 1'b0;
                        r_state <= S_FIN;
                    end else if (w_wd_expired) begin
                        r_we    <= 1'b0;
                        r_error <= 1'b1;
                        r_state <= S_FIN;
                    end else begin
                        r_wd <= r_wd + 1'b1;
                    end
                end
                S_GAP_W: begin
                    if (abort) begin
                        r_state <= S_FIN;
                    end else begin
                        r_state <= S_RD;
                        r_re    <= 1'b1;
                        r_addr  <= r_src;
                        r_wd    <= '0;
                    end
                end
                S_FIN: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_re    <= 1'b0;
                    r_we    <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign error      = r_error;
    assign words_done = r_words;
    assign ml_addr    = r_addr;
    assign ml_data_in = r_data_in;
    assign ml_we      = r_we;
    assign ml_re      = r_re;

endmodule
